// File: rtl/stable_tx_pkg.sv
// Shared types and width helpers for the stable_tx bit-serial transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stable_tx_pkg;

  // Frame-sequencing states, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int WIDTH_DEF = 8;
  localparam int HOLD_DEF  = 3;

  // Bit index width: enough to count 0..WIDTH-1
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // Hold counter width: one extra bit so HOLD=1 still yields a 1-bit counter
  function automatic int hcnt_w(input int hold);
    return $clog2(hold) + 1;
  endfunction

  localparam int IDX_W_DEF  = idx_w(WIDTH_DEF);
  localparam int HCNT_W_DEF = hcnt_w(HOLD_DEF);

endpackage

// File: rtl/stable_tx_if.sv
// Operand/strobe inputs and serial line/status outputs of stable_tx.
// Latency: n/a (wiring only).
// Backpressure: none; LOAD is simply ignored while a frame is busy.
interface stable_tx_if
  import stable_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic [WIDTH-1:0] D;
  logic             LOAD;
  logic             O;
  logic             E;
  logic             BUSY;
  logic             DONE;

  // Master issues operands and watches the line; slave is the transmitter
  modport master (output D, LOAD, input O, E, BUSY, DONE);
  modport slave  (input D, LOAD, output O, E, BUSY, DONE);

endinterface

// File: rtl/stable_tx_shreg.sv
// WIDTH-bit parallel-load shift-right register; LSB is the serial bit.
// Latency: LSB reflects DIN[0] one cycle after LD, next bit one cycle after SH.
// Backpressure: none; LD wins over SH, RST wins over both.
module stable_tx_shreg
  import stable_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic             SH,
  input  logic [WIDTH-1:0] DIN,
  output logic             LSB
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next contents: load beats shift, zero fill from the top
  always_comb begin
    sr_d = sr_q;
    if (LD) begin
      sr_d = DIN;
    end else if (SH) begin
      sr_d = {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // Register with synchronous clear
  always_ff @(posedge CLK) begin
    if (RST) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The LSB flop doubles as the registered line driver: it only changes on
  // edges that enter SETUP (load or shift) and holds after the last bit.
  assign LSB = sr_q[0];

endmodule

// File: rtl/stable_tx.sv
// Serialises a WIDTH-bit operand LSB first: 1 setup cycle (E=0) + HOLD stable cycles (E=1) per bit.
// Latency: first bit on O one cycle after accepted LOAD; DONE at WIDTH*(HOLD+1)+1.
// Backpressure: LOAD accepted only in IDLE; otherwise dropped, never queued.
module stable_tx
  import stable_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input logic        CLK,
  input logic        RST,
  stable_tx_if.slave bus
);

  localparam int IDX_W  = idx_w(WIDTH);
  localparam int HCNT_W = hcnt_w(HOLD);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);
  localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(HOLD - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic                e_q, e_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sr_ld;
  logic                sr_sh;
  logic                line;

  stable_tx_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .CLK (CLK),
    .RST (RST),
    .LD  (sr_ld),
    .SH  (sr_sh),
    .DIN (bus.D),
    .LSB (line)
  );

  // Next state, counters and shift-register controls
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hcnt_d  = hcnt_q;
    sr_ld   = 1'b0;
    sr_sh   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.LOAD) begin
          state_d = ST_SETUP;
          sr_ld   = 1'b1;
          idx_d   = '0;
          hcnt_d  = '0;
        end
      end
      ST_SETUP: begin
        state_d = ST_HOLD;
        hcnt_d  = '0;
      end
      ST_HOLD: begin
        if (hcnt_q == HCNT_LAST) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SETUP;
            idx_d   = idx_q + 1'b1;
            sr_sh   = 1'b1;
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    e_d    = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered status outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q  <= '0;
      hcnt_q <= '0;
      e_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      hcnt_q <= hcnt_d;
      e_q    <= e_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.O    = line;
  assign bus.E    = e_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_stable_tx.sv
// Scoreboard bench for stable_tx: stimulus pushes per-cycle expected outputs,
// negedge monitors pop and compare, plus an E/O stability watcher per instance.
module tb_stable_tx;

  typedef struct {
    int   cyc;
    logic o;
    logic e;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t xa;
  exp_t xb;

  logic prev_e_a, prev_o_a, prev_e_b, prev_o_b;

  stable_tx_if #(.WIDTH(8)) ifa ();
  stable_tx_if #(.WIDTH(2)) ifb ();

  stable_tx #(.WIDTH(8), .HOLD(3)) dut_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (ifa)
  );

  stable_tx #(.WIDTH(2), .HOLD(1)) dut_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (ifb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input int c, input logic o, input logic e,
                              input logic b, input logic dn);
    exp_t x;
    x.cyc = c; x.o = o; x.e = e; x.busy = b; x.done = dn;
    return x;
  endfunction

  task automatic cmp(input string name, input exp_t x, input logic o,
                     input logic e, input logic b, input logic dn);
    checks++;
    if (o !== x.o || e !== x.e || b !== x.busy || dn !== x.done) begin
      errors++;
      $display("FAIL %s cyc=%0d got O=%b E=%b BUSY=%b DONE=%b want O=%b E=%b BUSY=%b DONE=%b",
               name, x.cyc, o, e, b, dn, x.o, x.e, x.busy, x.done);
    end
  endtask

  // Expected outputs of an 8-bit/HOLD=3 frame loaded while cyc==c, frame cycles 1..last
  task automatic push_frame_a(input int c, input logic [7:0] d, input int last);
    for (int j = 1; j <= last && j <= 34; j++) begin
      if (j <= 32) begin
        qa.push_back(mk(c + j, d[(j - 1) / 4], ((j - 1) % 4) != 0, 1'b1, 1'b0));
      end else if (j == 33) begin
        qa.push_back(mk(c + j, d[7], 1'b0, 1'b1, 1'b1));
      end else begin
        qa.push_back(mk(c + j, d[7], 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, instance A
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL a_missed cyc=%0d got no sample want one at cyc=%0d", cyc, qa[0].cyc);
      void'(qa.pop_front());
    end
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      xa = qa.pop_front();
      cmp("a_frame", xa, ifa.O, ifa.E, ifa.BUSY, ifa.DONE);
    end
  end

  // Scoreboard monitor, instance B
  always @(negedge clk) begin
    while (qb.size() > 0 && qb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL b_missed cyc=%0d got no sample want one at cyc=%0d", cyc, qb[0].cyc);
      void'(qb.pop_front());
    end
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      xb = qb.pop_front();
      cmp("b_frame", xb, ifb.O, ifb.E, ifb.BUSY, ifb.DONE);
    end
  end

  // Change-detect watcher: O must not move across consecutive E=1 cycles
  always @(negedge clk) begin
    if (prev_e_a === 1'b1 && ifa.E === 1'b1) begin
      checks++;
      if (ifa.O !== prev_o_a) begin
        errors++;
        $display("FAIL a_stable cyc=%0d got O=%b want O=%b", cyc, ifa.O, prev_o_a);
      end
    end
    if (prev_e_b === 1'b1 && ifb.E === 1'b1) begin
      checks++;
      if (ifb.O !== prev_o_b) begin
        errors++;
        $display("FAIL b_stable cyc=%0d got O=%b want O=%b", cyc, ifb.O, prev_o_b);
      end
    end
    prev_e_a = ifa.E; prev_o_a = ifa.O;
    prev_e_b = ifb.E; prev_o_b = ifb.O;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got cyc=%0d want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] rd;
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.LOAD = 1'b0; ifa.D = '0;
    ifb.LOAD = 1'b0; ifb.D = '0;
    repeat (3) tick();

    // Reset state on both instances
    c = cyc;
    for (int j = 0; j < 3; j++) begin
      qa.push_back(mk(c + j, 1'b0, 1'b0, 1'b0, 1'b0));
      qb.push_back(mk(c + j, 1'b0, 1'b0, 1'b0, 1'b0));
    end
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) tick();

    // WIDTH=2, HOLD=1, D=2'b10: hand table
    c = cyc;
    ifb.D = 2'b10; ifb.LOAD = 1'b1;
    qb.push_back(mk(c + 1, 1'b0, 1'b0, 1'b1, 1'b0));
    qb.push_back(mk(c + 2, 1'b0, 1'b1, 1'b1, 1'b0));
    qb.push_back(mk(c + 3, 1'b1, 1'b0, 1'b1, 1'b0));
    qb.push_back(mk(c + 4, 1'b1, 1'b1, 1'b1, 1'b0));
    qb.push_back(mk(c + 5, 1'b1, 1'b0, 1'b1, 1'b1));
    qb.push_back(mk(c + 6, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    ifb.LOAD = 1'b0;
    repeat (7) tick();

    // D=A5: O slots 1,0,1,0,0,1,0,1; DONE at 33
    c = cyc;
    ifa.D = 8'hA5; ifa.LOAD = 1'b1;
    push_frame_a(c, 8'hA5, 34);
    tick();
    ifa.LOAD = 1'b0;
    repeat (34) tick();

    // D=00 frame, LOAD with D=FF at frame cycle 10 is ignored
    c = cyc;
    ifa.D = 8'h00; ifa.LOAD = 1'b1;
    push_frame_a(c, 8'h00, 34);
    tick();
    ifa.LOAD = 1'b0;
    repeat (9) tick();
    ifa.D = 8'hFF; ifa.LOAD = 1'b1;
    tick();
    ifa.LOAD = 1'b0;
    repeat (24) tick();

    // Reset at frame cycle 14 together with LOAD; then a clean frame
    c = cyc;
    ifa.D = 8'h0F; ifa.LOAD = 1'b1;
    push_frame_a(c, 8'h0F, 14);
    qa.push_back(mk(c + 15, 1'b0, 1'b0, 1'b0, 1'b0));
    push_frame_a(c + 15, 8'h81, 34);
    tick();
    ifa.LOAD = 1'b0;
    repeat (13) tick();
    rst_a = 1'b1; ifa.LOAD = 1'b1; ifa.D = 8'hFF;
    tick();
    rst_a = 1'b0; ifa.LOAD = 1'b1; ifa.D = 8'h81;
    tick();
    ifa.LOAD = 1'b0;
    repeat (35) tick();

    // LOAD held high: restart sampled at edge 34; D edited mid-frame
    c = cyc;
    ifa.D = 8'h5A; ifa.LOAD = 1'b1;
    push_frame_a(c, 8'h5A, 34);
    push_frame_a(c + 34, 8'h96, 34);
    repeat (5) tick();
    ifa.D = 8'h96;
    repeat (31) tick();
    ifa.LOAD = 1'b0;
    repeat (34) tick();

    // 100 random frames, full scoreboard plus stability watcher
    for (int n = 0; n < 100; n++) begin
      c = cyc;
      rd = 8'($urandom);
      ifa.D = rd; ifa.LOAD = 1'b1;
      push_frame_a(c, rd, 34);
      tick();
      ifa.LOAD = 1'b0;
      repeat (34) tick();
    end

    repeat (3) tick();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got qa=%0d qb=%0d want 0 0", qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
